// File: rtl/multi_pulse_controller.sv
// Multi-channel pushbutton front end.
// Each channel synchronizes a raw switch level, debounces press and release,
// emits a single-cycle pulse per press, optional auto-repeat pulses while
// held, and a single-cycle pulse per debounced release.
module multi_pulse_controller #(
    parameter int NCH          = 4,
    parameter int CNT_W        = 25,
    parameter int DEBOUNCE     = 2000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic           CLK,
    input  logic           clear,
    input  logic [NCH-1:0] sw_input,
    input  logic [NCH-1:0] repeat_en,
    output logic [NCH-1:0] clk_pulse,
    output logic [NCH-1:0] release_pulse,
    output logic [NCH-1:0] held
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    // Reload values are interval-minus-one so a counter that starts at the
    // load value and decrements to zero spans exactly the full interval.
    localparam logic [CNT_W-1:0] DB_LOAD = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LOAD = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             sync_a;
        logic             sync_s;
        state_t           state;
        state_t           state_nx;
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] count_nx;
        logic             pulse_q;
        logic             pulse_nx;
        logic             rel_q;
        logic             rel_nx;
        logic             held_q;
        logic             held_nx;

        // Two-flop synchronizer bringing the raw switch level into the clock domain
        always_ff @(posedge CLK or posedge clear) begin
            if (clear) begin
                sync_a <= 1'b0;
                sync_s <= 1'b0;
            end else begin
                sync_a <= sw_input[i];
                sync_s <= sync_a;
            end
        end

        // Channel state, timing counter and registered outputs
        always_ff @(posedge CLK or posedge clear) begin
            if (clear) begin
                state   <= IDLE;
                count   <= '0;
                pulse_q <= 1'b0;
                rel_q   <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                state   <= state_nx;
                count   <= count_nx;
                pulse_q <= pulse_nx;
                rel_q   <= rel_nx;
                held_q  <= held_nx;
            end
        end

        // Next-state, counter and pulse decisions; release beats a due repeat
        always_comb begin
            state_nx = state;
            count_nx = count;
            pulse_nx = 1'b0;
            rel_nx   = 1'b0;
            case (state)
                IDLE: begin
                    if (sync_s) begin
                        state_nx = PRESS_DB;
                        count_nx = DB_LOAD;
                        pulse_nx = 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (count == '0) begin
                        state_nx = HELD;
                        count_nx = RD_LOAD;
                    end else begin
                        count_nx = count - ONE;
                    end
                end
                HELD: begin
                    if (!sync_s) begin
                        state_nx = REL_DB;
                        count_nx = DB_LOAD;
                        rel_nx   = 1'b1;
                    end else if (!repeat_en[i]) begin
                        count_nx = RD_LOAD;
                    end else if (count == '0) begin
                        pulse_nx = 1'b1;
                        count_nx = RR_LOAD;
                    end else begin
                        count_nx = count - ONE;
                    end
                end
                REL_DB: begin
                    if (count == '0) begin
                        state_nx = IDLE;
                    end else begin
                        count_nx = count - ONE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    count_nx = '0;
                end
            endcase
            held_nx = (state_nx == PRESS_DB) || (state_nx == HELD);
        end

        assign clk_pulse[i]     = pulse_q;
        assign release_pulse[i] = rel_q;
        assign held[i]          = held_q;
    end

endmodule

// File: tb/tb_multi_pulse_controller.sv
// Self-checking bench for multi_pulse_controller with two channels and short
// timing parameters. A timestamp-based reference model predicts every output
// each cycle; stimulus is a set of directed scenarios followed by random runs.
module tb_multi_pulse_controller;

    localparam int NCH   = 2;
    localparam int CNT_W = 8;
    localparam int DB    = 4;
    localparam int RDLY  = 10;
    localparam int RRATE = 3;

    logic           clk_i;
    logic           clear;
    logic [NCH-1:0] sw_input;
    logic [NCH-1:0] repeat_en;
    logic [NCH-1:0] clk_pulse;
    logic [NCH-1:0] release_pulse;
    logic [NCH-1:0] held;

    int compared;
    int mismatched;

    multi_pulse_controller #(
        .NCH         (NCH),
        .CNT_W       (CNT_W),
        .DEBOUNCE    (DB),
        .REPEAT_DELAY(RDLY),
        .REPEAT_RATE (RRATE)
    ) dut (
        .CLK          (clk_i),
        .clear        (clear),
        .sw_input     (sw_input),
        .repeat_en    (repeat_en),
        .clk_pulse    (clk_pulse),
        .release_pulse(release_pulse),
        .held         (held)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: per channel a phase (0 idle, 1 press debounce,
    // 2 held, 3 release debounce) plus absolute edge timestamps.
    int             edge_t;
    int             phase    [NCH];
    int             mark     [NCH];
    int             next_due [NCH];
    logic [NCH-1:0] pipe_a;
    logic [NCH-1:0] pipe_s;
    logic [NCH-1:0] exp_pulse;
    logic [NCH-1:0] exp_rel;
    logic [NCH-1:0] exp_held;

    task automatic modelReset();
        edge_t    = 0;
        pipe_a    = '0;
        pipe_s    = '0;
        exp_pulse = '0;
        exp_rel   = '0;
        exp_held  = '0;
        for (int c = 0; c < NCH; c++) begin
            phase[c]    = 0;
            mark[c]     = 0;
            next_due[c] = 0;
        end
    endtask

    // One rising edge of the model; sw is what the synchronizer samples now.
    task automatic modelEdge(input logic [NCH-1:0] sw, input logic [NCH-1:0] en);
        logic level;
        edge_t = edge_t + 1;
        for (int c = 0; c < NCH; c++) begin
            level        = pipe_s[c];
            exp_pulse[c] = 1'b0;
            exp_rel[c]   = 1'b0;
            case (phase[c])
                0: if (level) begin
                    exp_pulse[c] = 1'b1;
                    phase[c]     = 1;
                    mark[c]      = edge_t;
                end
                1: if (edge_t == mark[c] + DB) begin
                    phase[c]    = 2;
                    next_due[c] = edge_t + RDLY;
                end
                2: if (!level) begin
                    exp_rel[c] = 1'b1;
                    phase[c]   = 3;
                    mark[c]    = edge_t;
                end else if (!en[c]) begin
                    next_due[c] = edge_t + RDLY;
                end else if (edge_t == next_due[c]) begin
                    exp_pulse[c] = 1'b1;
                    next_due[c]  = edge_t + RRATE;
                end
                default: if (edge_t == mark[c] + DB) phase[c] = 0;
            endcase
            exp_held[c] = (phase[c] == 1) || (phase[c] == 2);
        end
        pipe_s = pipe_a;
        pipe_a = sw;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared = compared + 1;
        if (observed !== expected) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", tag, $time,
                     observed, expected);
        end
    endtask

    task automatic checkAll(input string phase_tag);
        checkOutput({phase_tag, ".clk_pulse"}, 32'(clk_pulse), 32'(exp_pulse));
        checkOutput({phase_tag, ".release_pulse"}, 32'(release_pulse), 32'(exp_rel));
        checkOutput({phase_tag, ".held"}, 32'(held), 32'(exp_held));
    endtask

    // Drive one cycle of inputs at the falling edge, clock it, check outputs.
    task automatic applyStimulus(input logic [NCH-1:0] sw, input logic [NCH-1:0] en,
                                 input string tag);
        sw_input  = sw;
        repeat_en = en;
        modelEdge(sw, en);
        @(posedge clk_i);
        @(negedge clk_i);
        checkAll(tag);
    endtask

    task automatic runCycles(input logic [NCH-1:0] sw, input logic [NCH-1:0] en,
                             input int n, input string tag);
        for (int k = 0; k < n; k++) applyStimulus(sw, en, tag);
    endtask

    // Assert clear mid-cycle, confirm outputs drop without waiting for an edge.
    task automatic pulseClear(input string tag);
        #1;
        clear = 1'b1;
        #1;
        modelReset();
        checkAll({tag, ".async"});
        @(negedge clk_i);
        @(negedge clk_i);
        checkAll({tag, ".held_in_clear"});
        clear = 1'b0;
    endtask

    int             run_left [NCH];
    logic [NCH-1:0] sw_r;
    logic [NCH-1:0] en_r;

    initial begin
        compared   = 0;
        mismatched = 0;
        clear      = 1'b1;
        sw_input   = '0;
        repeat_en  = '0;
        modelReset();
        @(negedge clk_i);
        @(negedge clk_i);
        checkAll("reset");
        clear = 1'b0;

        // Single press, no repeat, then release
        runCycles(2'b01, 2'b00, 20, "press_only");
        runCycles(2'b00, 2'b00, 10, "press_only_rel");

        // Bounce on the leading edge
        applyStimulus(2'b01, 2'b00, "bounce");
        applyStimulus(2'b00, 2'b00, "bounce");
        applyStimulus(2'b01, 2'b00, "bounce");
        applyStimulus(2'b00, 2'b00, "bounce");
        applyStimulus(2'b01, 2'b00, "bounce");
        runCycles(2'b01, 2'b00, 12, "bounce_hold");
        runCycles(2'b00, 2'b00, 10, "bounce_rel");

        // Auto-repeat on channel 1
        runCycles(2'b10, 2'b10, 30, "repeat_ch1");
        runCycles(2'b00, 2'b10, 10, "repeat_ch1_rel");

        // Simultaneous press, independent release
        runCycles(2'b11, 2'b00, 8, "both");
        runCycles(2'b01, 2'b00, 6, "ch1_released");
        runCycles(2'b00, 2'b00, 10, "both_rel");

        // Clear while held, input stays high and re-presses afterwards
        runCycles(2'b01, 2'b00, 8, "pre_clear");
        pulseClear("clear_held");
        runCycles(2'b01, 2'b00, 6, "post_clear");
        runCycles(2'b00, 2'b00, 10, "post_clear_rel");

        // Release lands exactly when the first repeat is due
        runCycles(2'b01, 2'b01, 14, "coincide");
        runCycles(2'b00, 2'b01, 10, "coincide_rel");

        // Repeat enable raised late restarts the full delay
        runCycles(2'b01, 2'b00, 12, "late_en_a");
        runCycles(2'b01, 2'b01, 20, "late_en_b");
        runCycles(2'b00, 2'b00, 10, "late_en_rel");

        // Random runs of varying length with occasional clear
        sw_r = '0;
        en_r = '0;
        for (int c = 0; c < NCH; c++) run_left[c] = $urandom_range(1, 20);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if (run_left[c] == 0) begin
                    sw_r[c]     = ~sw_r[c];
                    run_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                              : int'($urandom_range(4, 40));
                end else begin
                    run_left[c] = run_left[c] - 1;
                end
                if ($urandom_range(0, 29) == 0) en_r[c] = ~en_r[c];
            end
            if ($urandom_range(0, 599) == 0) pulseClear("rand_clear");
            applyStimulus(sw_r, en_r, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
